// File: rtl/cdf_scan_pkg.sv
// Shared types and helpers for the CDF scan engine: FSM encoding, address
// width derivation and the accumulator clamp value.
package cdf_scan_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t READ  = 2'd1;
  localparam state_t DRAIN = 2'd2;
  localparam state_t FIN   = 2'd3;

  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [63:0] acc_max(input int w);
    return {64{1'b1}} >> (64 - w);
  endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Single W-bit adder with carry out; optionally clamps to all-ones on carry.
module acc_sat_add
  import cdf_scan_pkg::*;
#(
  parameter int W        = 16,
  parameter int SATURATE = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  localparam logic [W-1:0] MAX = W'(acc_max(W));

  logic [W:0] raw;

  assign raw   = {1'b0, a} + {1'b0, b};
  assign carry = raw[W];
  assign sum   = (SATURATE != 0 && carry) ? MAX : raw[W-1:0];

endmodule

// File: rtl/cdf_scan_engine.sv
// Sequential prefix-sum engine: streams N_BINS bins from a sync-read RAM,
// writes running sums one per cycle, reports total / first non-zero / overflow.
module cdf_scan_engine
  import cdf_scan_pkg::*;
#(
  parameter int  N_BINS   = 256,
  parameter int  DATA_W   = 16,
  parameter int  ACC_W    = 16,
  parameter int  SATURATE = 1,
  localparam int ADDR_W   = addr_w(N_BINS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              excl,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ACC_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  total,
  output logic [ACC_W-1:0]  cdf_min,
  output logic              overflow
);

  localparam int STAGES = 2;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_BINS - 1);

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [ADDR_W-1:0]   addr_d1;
  logic [STAGES:1]     vld_pipe;
  logic                excl_q;
  logic                found;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    inc;
  logic                carry;

  assign rd_en   = (state == READ);
  assign rd_addr = rd_en ? cnt : '0;
  assign wr_en   = vld_pipe[STAGES];
  assign busy    = (state == READ) || (state == DRAIN);
  assign done    = (state == FIN);

  acc_sat_add #(.W(ACC_W), .SATURATE(SATURATE)) u_add (
    .a     (acc),
    .b     (ACC_W'(rd_data)),
    .sum   (inc),
    .carry (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_d1  <= '0;
      vld_pipe <= '0;
      excl_q   <= 1'b0;
      found    <= 1'b0;
      acc      <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      total    <= '0;
      cdf_min  <= '0;
      overflow <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], rd_en};
      addr_d1  <= rd_addr;

      // Stage 2: rd_data for the bin read last cycle is on the bus now.
      if (vld_pipe[1]) begin
        acc     <= inc;
        wr_addr <= addr_d1;
        wr_data <= excl_q ? acc : inc;
        if (carry) overflow <= 1'b1;
        if (!found && inc != '0) begin
          found   <= 1'b1;
          cdf_min <= inc;
        end
      end

      case (state)
        IDLE: if (start) begin
          state    <= READ;
          cnt      <= '0;
          excl_q   <= excl;
          acc      <= '0;
          overflow <= 1'b0;
          cdf_min  <= '0;
          found    <= 1'b0;
        end
        READ: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DRAIN;
            cnt   <= '0;
          end
        end
        DRAIN: begin
          cnt <= cnt + 1'b1;
          // Pipeline has fully retired by the second drain cycle.
          if (cnt == ADDR_W'(1)) begin
            state <= FIN;
            total <= acc;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdf_scan_engine.sv
// Scoreboard bench: a saturating and a wrapping engine (N_BINS=8) scan the
// same bin memory; expected writes are queued at start and popped per write.
module tb_cdf_scan_engine;

  localparam int N = 8;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        excl = 1'b0;

  logic        rd_en_s, wr_en_s, busy_s, done_s, ov_s;
  logic [2:0]  rd_addr_s, wr_addr_s;
  logic [15:0] rd_data_s, wr_data_s, total_s, min_s;
  logic        rd_en_w, wr_en_w, busy_w, done_w, ov_w;
  logic [2:0]  rd_addr_w, wr_addr_w;
  logic [15:0] rd_data_w, wr_data_w, total_w, min_w;

  logic [15:0] mem [N];
  wr_t q_s[$];
  wr_t q_w[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  int  exp_tot_s, exp_min_s, exp_tot_w, exp_min_w;
  logic exp_ov_s, exp_ov_w;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cdf_scan_engine #(.N_BINS(N), .DATA_W(16), .ACC_W(16), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .excl(excl),
    .rd_en(rd_en_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
    .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
    .busy(busy_s), .done(done_s), .total(total_s), .cdf_min(min_s), .overflow(ov_s)
  );

  cdf_scan_engine #(.N_BINS(N), .DATA_W(16), .ACC_W(16), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .excl(excl),
    .rd_en(rd_en_w), .rd_addr(rd_addr_w), .rd_data(rd_data_w),
    .wr_en(wr_en_w), .wr_addr(wr_addr_w), .wr_data(wr_data_w),
    .busy(busy_w), .done(done_w), .total(total_w), .cdf_min(min_w), .overflow(ov_w)
  );

  always @(posedge clk) begin
    if (rd_en_s) rd_data_s <= mem[rd_addr_s];
    if (rd_en_w) rd_data_w <= mem[rd_addr_w];
  end

  // Write monitor: every DUT write must match the head of its queue.
  always @(negedge clk) begin
    wr_t it;
    if (wr_en_s) begin
      checks++;
      if (q_s.size() == 0) begin
        failures++;
        $display("FAIL sat_write unexpected: addr=%0d data=%h cyc=%0d", wr_addr_s, wr_data_s, cyc);
      end else begin
        it = q_s.pop_front();
        if (wr_addr_s !== 3'(it.addr) || wr_data_s !== 16'(it.data) || cyc != it.cyc) begin
          failures++;
          $display("FAIL sat_write: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d",
                   wr_addr_s, wr_data_s, cyc, it.addr, it.data, it.cyc);
        end
      end
    end
    if (wr_en_w) begin
      checks++;
      if (q_w.size() == 0) begin
        failures++;
        $display("FAIL wrap_write unexpected: addr=%0d data=%h cyc=%0d", wr_addr_w, wr_data_w, cyc);
      end else begin
        it = q_w.pop_front();
        if (wr_addr_w !== 3'(it.addr) || wr_data_w !== 16'(it.data) || cyc != it.cyc) begin
          failures++;
          $display("FAIL wrap_write: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d",
                   wr_addr_w, wr_data_w, cyc, it.addr, it.data, it.cyc);
        end
      end
    end
  end

  task automatic fill(input int b0, input int b1, input int b2, input int b3, input int rest);
    mem[0] = 16'(b0); mem[1] = 16'(b1); mem[2] = 16'(b2); mem[3] = 16'(b3);
    for (int i = 4; i < N; i++) mem[i] = 16'(rest);
  endtask

  // Reference model: integer arithmetic with explicit clamp / modulo.
  task automatic model(input logic ex, input int c0);
    int s, w, ps, pw;
    s = 0; w = 0;
    exp_ov_s = 0; exp_ov_w = 0; exp_min_s = 0; exp_min_w = 0;
    for (int k = 0; k < N; k++) begin
      ps = s; pw = w;
      s = s + mem[k];
      if (s > 65535) begin s = 65535; exp_ov_s = 1; end
      w = w + mem[k];
      if (w > 65535) begin w = w - 65536; exp_ov_w = 1; end
      if (exp_min_s == 0) exp_min_s = s;
      if (exp_min_w == 0) exp_min_w = w;
      q_s.push_back('{addr: k, data: ex ? ps : s, cyc: c0 + 2 + k});
      q_w.push_back('{addr: k, data: ex ? pw : w, cyc: c0 + 2 + k});
    end
    exp_tot_s = s; exp_tot_w = w;
  endtask

  task automatic wait_done(output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_s) begin
        dcyc = cyc;
        return;
      end
    end
  endtask

  task automatic check_results(input string tag, input int dcyc, input int want_cyc);
    checks++;
    if (dcyc != want_cyc) begin
      failures++;
      $display("FAIL %s done_cycle: got %0d want %0d", tag, dcyc, want_cyc);
    end
    checks++;
    if (done_w !== 1'b1) begin failures++; $display("FAIL %s wrap_done: got %b want 1", tag, done_w); end
    checks++;
    if (total_s !== 16'(exp_tot_s) || min_s !== 16'(exp_min_s) || ov_s !== exp_ov_s) begin
      failures++;
      $display("FAIL %s sat_status: total=%h min=%h ov=%b want total=%h min=%h ov=%b",
               tag, total_s, min_s, ov_s, 16'(exp_tot_s), 16'(exp_min_s), exp_ov_s);
    end
    checks++;
    if (total_w !== 16'(exp_tot_w) || min_w !== 16'(exp_min_w) || ov_w !== exp_ov_w) begin
      failures++;
      $display("FAIL %s wrap_status: total=%h min=%h ov=%b want total=%h min=%h ov=%b",
               tag, total_w, min_w, ov_w, 16'(exp_tot_w), 16'(exp_min_w), exp_ov_w);
    end
    @(negedge clk);
    checks++;
    if (done_s !== 1'b0 || busy_s !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse: done=%b busy=%b want 0 0", tag, done_s, busy_s);
    end
    checks++;
    if (q_s.size() != 0 || q_w.size() != 0) begin
      failures++;
      $display("FAIL %s missing_writes: sat=%0d wrap=%0d want 0 0", tag, q_s.size(), q_w.size());
    end
  endtask

  task automatic run_scan(input string tag, input logic ex, input bit glitch);
    int c0, dcyc;
    @(negedge clk);
    start = 1'b1; excl = ex;
    c0 = cyc + 1;
    model(ex, c0);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy_s !== 1'b1 || rd_en_s !== 1'b1 || rd_addr_s !== 3'd0) begin
      failures++;
      $display("FAIL %s first_read: busy=%b rd_en=%b addr=%0d want 1 1 0", tag, busy_s, rd_en_s, rd_addr_s);
    end
    if (glitch) begin
      repeat (3) @(negedge clk);
      start = 1'b1; excl = ~ex;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(dcyc);
    check_results(tag, dcyc, c0 + N + 2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_en_s, rd_addr_s, wr_en_s, wr_addr_s, wr_data_s, busy_s, done_s, total_s, min_s, ov_s} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0",
               {rd_en_s, rd_addr_s, wr_en_s, wr_addr_s, wr_data_s, busy_s, done_s, total_s, min_s, ov_s});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_inclusive();
    fill(1, 1, 1, 1, 1);
    run_scan("inclusive", 1'b0, 1'b0);
  endtask

  task automatic test_exclusive();
    fill(1, 1, 1, 1, 1);
    run_scan("exclusive", 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    fill(16'hFFFF, 2, 1, 0, 0);
    run_scan("overflow", 1'b0, 1'b0);
  endtask

  task automatic test_cdf_min();
    fill(0, 0, 5, 3, 0);
    run_scan("cdf_min", 1'b0, 1'b0);
    fill(0, 0, 0, 0, 0);
    run_scan("all_zero", 1'b0, 1'b0);
  endtask

  task automatic test_ignored_start();
    fill(3, 1, 4, 1, 5);
    run_scan("glitch_start", 1'b0, 1'b1);
    run_scan("restart_excl", 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int c0, dcyc;
    fill(2, 7, 1, 8, 2);
    @(negedge clk);
    start = 1'b1; excl = 1'b0;
    c0 = cyc + 1;
    model(1'b0, c0);
    model(1'b0, c0 + N + 4);
    wait_done(dcyc);
    checks++;
    if (dcyc != c0 + N + 2) begin
      failures++;
      $display("FAIL b2b first_done: got %0d want %0d", dcyc, c0 + N + 2);
    end
    repeat (2) @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy_s !== 1'b1 || rd_addr_s !== 3'd0) begin
      failures++;
      $display("FAIL b2b restart: busy=%b addr=%0d want 1 0", busy_s, rd_addr_s);
    end
    wait_done(dcyc);
    check_results("b2b_second", dcyc, c0 + 2 * N + 6);
  endtask

  task automatic test_reset_mid_scan();
    int c0;
    bit seen;
    fill(4, 4, 4, 4, 4);
    @(negedge clk);
    start = 1'b1; excl = 1'b0;
    c0 = cyc + 1;
    model(1'b0, c0);
    @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + 4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    q_s.delete();
    q_w.delete();
    checks++;
    if ({rd_en_s, rd_addr_s, wr_en_s, wr_addr_s, wr_data_s, busy_s, done_s, total_s, min_s, ov_s} !== '0) begin
      failures++;
      $display("FAIL async_reset_outputs: got %h want 0",
               {rd_en_s, rd_addr_s, wr_en_s, wr_addr_s, wr_data_s, busy_s, done_s, total_s, min_s, ov_s});
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_s || done_w) seen = 1;
      if (i == 3) rst_n = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort_no_done: got done pulse want none");
    end
    run_scan("after_reset", 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_inclusive();
    test_exclusive();
    test_overflow();
    test_cdf_min();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_scan();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdf_scan_engine.md
Name: cdf_scan_engine

Overview:
- Sequential, parametrised prefix-sum (cumulative histogram / CDF) engine.
- On `start`, it streams N_BINS histogram bins from an external synchronous-read bin RAM.
- It writes the running sums to an external CDF RAM port, one bin per cycle.
- It reports the total count, the first non-zero CDF value (for histogram equalisation) and an overflow flag.
- It replaces the fully-unrolled combinational adder chain with one adder plus a pipeline.

Parameters:
- N_BINS, 256, number of bins scanned; must be >= 2.
- DATA_W, 16, width of one histogram bin.
- ACC_W, 16, width of the accumulator and the CDF output; must be >= DATA_W.
- SATURATE, 1, 1 = clamp at 2^ACC_W-1; 0 = wrap modulo 2^ACC_W.
- ADDR_W, $clog2(N_BINS), address width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a scan; sampled only in IDLE.
- excl  in  1  captured at start; 0 = inclusive prefix, 1 = exclusive prefix.
- rd_en  out  1  bin RAM read enable.
- rd_addr  out  ADDR_W  bin RAM address.
- rd_data  in  DATA_W  bin RAM data; valid exactly 1 cycle after rd_en.
- wr_en  out  1  CDF RAM write enable.
- wr_addr  out  ADDR_W  CDF RAM address.
- wr_data  out  ACC_W  CDF value.
- busy  out  1  scan in progress.
- done  out  1  single-cycle pulse at scan end.
- total  out  ACC_W  final inclusive sum; held until the next start.
- cdf_min  out  ACC_W  first non-zero inclusive sum; 0 if all bins are zero.
- overflow  out  1  sticky per scan; set on any carry out of ACC_W.

Behaviour:
- Reset:
  - All outputs are 0.
  - The FSM goes to IDLE.
  - The accumulator and counters are cleared.
  - Reset mid-scan aborts immediately: no further rd_en/wr_en, and no done pulse.
- FSM states: IDLE -> READ -> DRAIN -> FIN -> IDLE.
  - IDLE: start=1 at edge E0 captures excl, clears acc/overflow/cdf_min/found, and moves to READ.
  - READ: in cycle E0+1+k (k = 0..N_BINS-1), rd_en=1 and rd_addr=k. After k=N_BINS-1 the FSM moves to DRAIN.
  - DRAIN: waits 2 cycles for the last data and the last write, then moves to FIN.
  - FIN: done=1 for exactly 1 cycle, then the FSM returns to IDLE.
- Pipeline:
  - rd_data for bin k is valid 1 cycle after its read.
  - The adder result is registered, so wr_en/wr_addr=k/wr_data appear exactly 2 cycles after the read of bin k.
  - Throughput is 1 bin/cycle.
- Timing:
  - Last write occurs at cycle E0+N_BINS+2.
  - done pulses at E0+N_BINS+3.
  - busy=1 from E0+1 through E0+N_BINS+2 inclusive.
- Arithmetic:
  - rd_data is zero-extended to ACC_W.
  - inc_k = acc_{k-1} + bin_k, with acc_{-1} = 0.
  - Inclusive mode: wr_data = inc_k.
  - Exclusive mode: wr_data = acc_{k-1`}` (bin 0 writes 0).
  - SATURATE=1: on carry, inc_k = 2^ACC_W-1 and stays clamped for the rest of the scan.
  - SATURATE=0: wrap modulo 2^ACC_W.
  - In both modes, a carry sets overflow.
- cdf_min: latched on the first k with inc_k != 0. It updates only once per scan.
- total: updated with inc_{N-1} on the cycle done asserts. It keeps its previous value during the scan.
- Handshake edge cases:
  - start is ignored while busy or in FIN.
  - start in the same cycle as done (FIN) is ignored; a restart is accepted from the following IDLE cycle.
  - start held high continuously re-triggers once per return to IDLE.
- overflow and cdf_min remain valid after done until the next accepted start.

Decomposition:
- Package cdf_scan_pkg:
  - state enum type (IDLE, READ, DRAIN, FIN);
  - localparam helpers for ADDR_W;
  - an ACC_MAX constant function.
- One sub-module, acc_sat_add:
  - parameters W and SATURATE;
  - inputs a, b; outputs sum and carry;
  - combinational single adder.

Test Plan:
- N_BINS=8, all bins=1, excl=0 -> wr_data 1..8 at addresses 0..7 on consecutive cycles; total=8; cdf_min=1; overflow=0; done exactly at E0+11.
- Same bins, excl=1 -> wr_data 0,1,...,7; total=8.
- SATURATE=1, ACC_W=16, bins {0xFFFF, 0x0002, 0x0001, 0, ...} -> wr_data 0xFFFF, 0xFFFF, 0xFFFF...; overflow=1; total=0xFFFF.
- SATURATE=0, same bins -> wr_data 0xFFFF, 0x0001, 0x0002, ...; overflow=1.
- Bins {0,0,5,3,0,...} -> cdf_min=5; all-zero bins -> cdf_min=0, total=0.
- Scan 1:
  - start pulsed at cycle E0+4 is ignored, with no extra writes;
  - scan then restarted with a new excl value, which takes effect.
- Scan 2:
  - rst_n driven low at E0+5 -> all outputs 0 asynchronously; no done pulse;
  - a fresh start then completes normally.
